// File: rtl/key_debounce_if.sv
// -----------------------------------------------------------------------------
// key_debounce_if
// Event channel between the key debouncer (master) and its consumer (slave).
//   evt_valid    : master -> slave, event register holds an unread event
//   evt_ready    : slave  -> master, consumer accepts the event this cycle
//   evt_code     : master -> slave, key index of the held event
//   evt_press    : master -> slave, 1 = press event, 0 = release event
//   evt_overflow : master -> slave, sticky flag, at least one event was dropped
// CODE_W must match the debouncer's code width (clog2(N_KEYS), minimum 1).
// -----------------------------------------------------------------------------
interface key_debounce_if #(
    parameter int CODE_W = 2
) ();
    logic              evt_valid;
    logic              evt_ready;
    logic [CODE_W-1:0] evt_code;
    logic              evt_press;
    logic              evt_overflow;

    modport master (
        output evt_valid,
        output evt_code,
        output evt_press,
        output evt_overflow,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_code,
        input  evt_press,
        input  evt_overflow,
        output evt_ready
    );
endinterface

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Debounces N_KEYS active-low push buttons. Each button is synchronised, then
// sampled once per tick (TICK_DIV clk cycles); a level change is accepted after
// STABLE_CNT consecutive ticks that disagree with the current debounced level.
// Accepted changes produce one-cycle press/release strobes and are queued in a
// single-entry event register with a valid/ready handshake.
//
// Ports:
//   clk           : clock, all logic on rising edge
//   rst           : synchronous active-high reset, highest priority
//   key_n         : raw buttons, active-low, asynchronous to clk
//   key_level     : debounced level, 1 = pressed
//   press_pulse   : one-cycle strobe, aligned with key_level rising
//   release_pulse : one-cycle strobe, aligned with key_level falling
//   evt           : event channel (valid/ready/code/press/overflow), master side
// -----------------------------------------------------------------------------
module key_debounce #(
    parameter int N_KEYS     = 4,
    parameter int TICK_DIV   = 25000,
    parameter int STABLE_CNT = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    key_debounce_if.master    evt
);

    localparam int CODE_W = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;
    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int STAB_W = $clog2(STABLE_CNT + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [STAB_W-1:0] STAB_TGT  = STAB_W'(STABLE_CNT);

    // synchroniser and sample
    logic [N_KEYS-1:0] key_meta_r;
    logic [N_KEYS-1:0] key_sync_r;
    logic [1:0]        sync_fill_r;
    logic              sync_ok_s;
    logic [N_KEYS-1:0] sample_s;

    // tick generation
    logic [TICK_W-1:0] tick_cnt_r;
    logic              tick_s;

    // per-key debounce state
    logic [STAB_W-1:0] stab_cnt_r [N_KEYS];
    logic [STAB_W-1:0] stab_inc_s [N_KEYS];
    logic [N_KEYS-1:0] differ_s;
    logic [N_KEYS-1:0] toggle_s;
    logic [N_KEYS-1:0] key_level_r;
    logic [N_KEYS-1:0] press_pulse_r;
    logic [N_KEYS-1:0] release_pulse_r;

    // event register
    logic              any_s;
    logic              multi_s;
    logic              free_s;
    logic              load_s;
    logic              drop_s;
    logic [CODE_W-1:0] sel_idx_s;
    logic              sel_press_s;
    logic              evt_valid_r;
    logic [CODE_W-1:0] evt_code_r;
    logic              evt_press_r;
    logic              evt_overflow_r;

    // Two-flop synchroniser; sync_fill_r marks when key_sync_r holds real samples
    always_ff @(posedge clk) begin
        if (rst) begin
            key_meta_r  <= {N_KEYS{1'b0}};
            key_sync_r  <= {N_KEYS{1'b0}};
            sync_fill_r <= 2'b00;
        end else begin
            key_meta_r  <= key_n;
            key_sync_r  <= key_meta_r;
            sync_fill_r <= {sync_fill_r[0], 1'b1};
        end
    end

    // The synchroniser resets to 0, which reads as "pressed" after inversion;
    // gating on sync_ok_s keeps those two reset-artefact cycles from counting
    // when TICK_DIV is small enough for a tick to land on them.
    assign sync_ok_s = sync_fill_r[1];
    assign sample_s  = ~key_sync_r;

    // Free-running sample tick divider
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_r <= {TICK_W{1'b0}};
        end else if (tick_s) begin
            tick_cnt_r <= {TICK_W{1'b0}};
        end else begin
            tick_cnt_r <= tick_cnt_r + TICK_W'(1);
        end
    end

    assign tick_s = (tick_cnt_r == TICK_LAST);

    // Per-key compare and toggle decision for the current tick
    always_comb begin
        differ_s = {N_KEYS{1'b0}};
        toggle_s = {N_KEYS{1'b0}};
        for (int i = 0; i < N_KEYS; i++) begin
            stab_inc_s[i] = stab_cnt_r[i] + STAB_W'(1);
            differ_s[i]   = sync_ok_s & (sample_s[i] ^ key_level_r[i]);
            toggle_s[i]   = tick_s & differ_s[i] & (stab_inc_s[i] == STAB_TGT);
        end
    end

    // Stability counters: advance on ticks that disagree, clear on agreement or toggle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_KEYS; i++) begin
                stab_cnt_r[i] <= {STAB_W{1'b0}};
            end
        end else if (tick_s) begin
            for (int i = 0; i < N_KEYS; i++) begin
                if (!differ_s[i] || toggle_s[i]) begin
                    stab_cnt_r[i] <= {STAB_W{1'b0}};
                end else begin
                    stab_cnt_r[i] <= stab_inc_s[i];
                end
            end
        end
    end

    // Debounced level and edge strobes; strobes line up with the new level
    always_ff @(posedge clk) begin
        if (rst) begin
            key_level_r     <= {N_KEYS{1'b0}};
            press_pulse_r   <= {N_KEYS{1'b0}};
            release_pulse_r <= {N_KEYS{1'b0}};
        end else begin
            key_level_r     <= key_level_r ^ toggle_s;
            press_pulse_r   <= toggle_s & ~key_level_r;
            release_pulse_r <= toggle_s & key_level_r;
        end
    end

    // Pick the lowest-index toggling key; scanning downward lets the lowest win
    always_comb begin
        sel_idx_s   = {CODE_W{1'b0}};
        sel_press_s = 1'b0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            sel_idx_s   = toggle_s[i] ? CODE_W'(i) : sel_idx_s;
            sel_press_s = toggle_s[i] ? ~key_level_r[i] : sel_press_s;
        end
    end

    // Event register load / drop decisions
    always_comb begin
        any_s   = |toggle_s;
        // x & (x-1) is non-zero exactly when more than one bit is set
        multi_s = |(toggle_s & (toggle_s - N_KEYS'(1)));
        free_s  = ~evt_valid_r | evt.evt_ready;
        load_s  = any_s & free_s;
        drop_s  = any_s & (~free_s | multi_s);
    end

    // Single-entry event register with valid/ready handshake and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_valid_r    <= 1'b0;
            evt_code_r     <= {CODE_W{1'b0}};
            evt_press_r    <= 1'b0;
            evt_overflow_r <= 1'b0;
        end else begin
            if (load_s) begin
                evt_valid_r <= 1'b1;
                evt_code_r  <= sel_idx_s;
                evt_press_r <= sel_press_s;
            end else if (evt_valid_r && evt.evt_ready) begin
                evt_valid_r <= 1'b0;
            end
            if (drop_s) begin
                evt_overflow_r <= 1'b1;
            end
        end
    end

    assign key_level        = key_level_r;
    assign press_pulse      = press_pulse_r;
    assign release_pulse    = release_pulse_r;
    assign evt.evt_valid    = evt_valid_r;
    assign evt.evt_code     = evt_code_r;
    assign evt.evt_press    = evt_press_r;
    assign evt.evt_overflow = evt_overflow_r;

endmodule

// File: tb/tb_key_debounce.sv
// -----------------------------------------------------------------------------
// tb_key_debounce
// Self-checking bench for key_debounce with TICK_DIV=4, STABLE_CNT=3, N_KEYS=4.
// Expected events are queued when a key change is driven and compared when the
// DUT hands them over on the event channel.
// -----------------------------------------------------------------------------
module tb_key_debounce;

    localparam int N_KEYS     = 4;
    localparam int TICK_DIV   = 4;
    localparam int STABLE_CNT = 3;

    typedef struct packed {
        logic [1:0] code;
        logic       press;
    } evt_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N_KEYS-1:0] key_n = 4'hF;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] press_pulse;
    logic [N_KEYS-1:0] release_pulse;

    key_debounce_if #(.CODE_W(2)) evt_if ();

    key_debounce #(
        .N_KEYS     (N_KEYS),
        .TICK_DIV   (TICK_DIV),
        .STABLE_CNT (STABLE_CNT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .key_n         (key_n),
        .key_level     (key_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .evt           (evt_if)
    );

    always #5 clk = ~clk;

    int   checks_cnt = 0;
    int   errors_cnt = 0;
    evt_t exp_q[$];
    int   press_cnt [N_KEYS];
    int   release_cnt [N_KEYS];

    initial begin
        for (int i = 0; i < N_KEYS; i++) begin
            press_cnt[i]   = 0;
            release_cnt[i] = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks_cnt++;
        if (act !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance n clock edges, then settle 3 time units past the edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic push_evt(input int code, input logic press);
        evt_t e;
        e.code  = 2'(code);
        e.press = press;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    // Scoreboard and strobe monitor, sampled on the falling edge
    always @(negedge clk) begin
        evt_t e;
        if (!rst) begin
            for (int i = 0; i < N_KEYS; i++) begin
                if (press_pulse[i]) begin
                    press_cnt[i]++;
                    chk("press_align", key_level[i], 1);
                end
                if (release_pulse[i]) begin
                    release_cnt[i]++;
                    chk("release_align", key_level[i], 0);
                end
            end
            if ((press_pulse | release_pulse) != 4'b0000) begin
                chk("pulse_excl", press_pulse & release_pulse, 0);
            end
            if (evt_if.evt_valid && evt_if.evt_ready) begin
                if (exp_q.size() == 0) begin
                    chk("evt_unexpected", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("evt_code", evt_if.evt_code, e.code);
                    chk("evt_press", evt_if.evt_press, e.press);
                end
            end
        end
    end

    initial begin
        int  n;
        bit  found;

        evt_if.evt_ready = 1'b0;

        // Reset state
        step(2);
        chk("rst_level", key_level, 0);
        chk("rst_press", press_pulse, 0);
        chk("rst_release", release_pulse, 0);
        chk("rst_valid", evt_if.evt_valid, 0);
        chk("rst_code", evt_if.evt_code, 0);
        chk("rst_evpress", evt_if.evt_press, 0);
        chk("rst_ovf", evt_if.evt_overflow, 0);
        rst = 1'b0;
        step(2);

        // Single press on key 0: latency window and event contents
        evt_if.evt_ready = 1'b1;
        push_evt(0, 1'b1);
        key_n[0] = 1'b0;
        n = 0;
        found = 1'b0;
        while (!found && n < 40) begin
            step(1);
            n++;
            if (key_level[0]) found = 1'b1;
        end
        chk("lat_found", found, 1);
        if ((n < 11) || (n > 14)) begin
            chk("lat_window", n, 11);
        end else begin
            chk("lat_window", (n >= 11) && (n <= 14), 1);
        end
        chk("k0_pulse", press_pulse, 4'b0001);
        chk("k0_valid", evt_if.evt_valid, 1);
        chk("k0_code", evt_if.evt_code, 0);
        chk("k0_evpress", evt_if.evt_press, 1);
        step(1);
        chk("k0_pulse_end", press_pulse, 4'b0000);
        push_evt(0, 1'b0);
        key_n[0] = 1'b1;
        step(20);
        chk("k0_released", key_level, 0);
        chk("k0_press_cnt", press_cnt[0], 1);
        chk("k0_release_cnt", release_cnt[0], 1);

        // Glitch on key 2 shorter than STABLE_CNT ticks
        key_n[2] = 1'b0;
        step(8);
        key_n[2] = 1'b1;
        step(20);
        chk("glitch_level", key_level, 0);
        chk("glitch_pulse", press_cnt[2], 0);
        chk("glitch_valid", evt_if.evt_valid, 0);

        // Keys 1 and 3 together: lowest index wins, other dropped
        push_evt(1, 1'b1);
        key_n = 4'b0101;
        step(20);
        chk("dual_level", key_level, 4'b1010);
        chk("dual_ovf", evt_if.evt_overflow, 1);
        chk("dual_p1", press_cnt[1], 1);
        chk("dual_p3", press_cnt[3], 1);
        push_evt(1, 1'b0);
        key_n = 4'hF;
        step(20);
        chk("dual_rel_level", key_level, 0);
        chk("dual_q_empty", exp_q.size(), 0);

        do_reset();
        chk("ovf_cleared", evt_if.evt_overflow, 0);
        step(2);

        // Consumer stalled: first event held, second dropped
        evt_if.evt_ready = 1'b0;
        key_n[0] = 1'b0;
        step(20);
        key_n[0] = 1'b1;
        step(20);
        chk("stall_level", key_level[0], 0);
        chk("stall_valid", evt_if.evt_valid, 1);
        chk("stall_code", evt_if.evt_code, 0);
        chk("stall_evpress", evt_if.evt_press, 1);
        chk("stall_ovf", evt_if.evt_overflow, 1);
        push_evt(0, 1'b1);
        evt_if.evt_ready = 1'b1;
        step(3);
        chk("stall_drained", exp_q.size(), 0);
        chk("stall_valid_clr", evt_if.evt_valid, 0);

        // Toggles on successive ticks, consumer always ready: order preserved
        push_evt(1, 1'b1);
        push_evt(2, 1'b1);
        key_n[1] = 1'b0;
        step(4);
        key_n[2] = 1'b0;
        step(25);
        chk("seq_level", key_level, 4'b0110);
        chk("seq_q_empty", exp_q.size(), 0);
        push_evt(1, 1'b0);
        push_evt(2, 1'b0);
        key_n[1] = 1'b1;
        step(4);
        key_n[2] = 1'b1;
        step(25);
        chk("seq_rel_level", key_level, 0);
        chk("seq_rel_q_empty", exp_q.size(), 0);

        // Reset mid-debounce discards partial count
        key_n[1] = 1'b0;
        step(10);
        chk("pre_rst_level", key_level, 0);
        do_reset();
        chk("mid_rst_level", key_level, 0);
        chk("mid_rst_pulse", press_pulse | release_pulse, 0);
        chk("mid_rst_valid", evt_if.evt_valid, 0);
        chk("mid_rst_ovf", evt_if.evt_overflow, 0);
        chk("mid_rst_code", {evt_if.evt_code, evt_if.evt_press}, 0);
        push_evt(1, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            step(1);
            if (k == 11) chk("rst_hold_11", key_level[1], 0);
            if (k == 12) begin
                chk("rst_hold_12", key_level[1], 1);
                chk("rst_hold_pulse", press_pulse, 4'b0010);
            end
        end
        push_evt(1, 1'b0);
        key_n[1] = 1'b1;
        step(20);
        chk("final_level", key_level, 0);
        chk("final_q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
